// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises two single-word masters onto one memory port.
// Round-robin or fixed CPU priority, with a watchdog that aborts hung accesses.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CPU_PRIORITY = 0,
    parameter int TIMEOUT      = 1023
) (
    input  logic                  clk50M,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_we,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_done,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_we,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_done,
    output logic                  m1_err,

    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,

    output logic [1:0]            grant,
    output logic [7:0]            err_count
);

    localparam int WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WD_W-1:0] WD_END = WD_W'(WD_LAST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            owner;
    logic            last_owner;
    logic [WD_W-1:0] wd_cnt;

    logic            any_req;
    logic            pick;
    logic            wd_hit;
    logic            start;
    logic            fin_ack;
    logic            fin_to;

    assign any_req = m0_req | m1_req;

    // The watchdog fires on the edge that would be the TIMEOUT-th BUSY edge.
    assign wd_hit = (TIMEOUT > 0) && (wd_cnt == WD_END);

    // Winner selection: a lone requester wins, ties go by priority mode.
    always_comb begin
        pick = 1'b0;
        if (m0_req && m1_req) begin
            pick = (CPU_PRIORITY != 0) ? 1'b0 : ~last_owner;
        end else if (m1_req) begin
            pick = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; DONE always lasts exactly one cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = BUSY;
            BUSY:    if (mem_ack || wd_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Transaction strobes; an ack beats a simultaneous timeout.
    always_comb begin
        start   = 1'b0;
        fin_ack = 1'b0;
        fin_to  = 1'b0;
        unique case (state)
            IDLE: start = any_req;
            BUSY: begin
                fin_ack = mem_ack;
                fin_to  = ~mem_ack & wd_hit;
            end
            default: ;
        endcase
    end

    // Ownership tracking and the busy-cycle watchdog counter.
    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            wd_cnt     <= '0;
        end else begin
            if (start) begin
                owner  <= pick;
                wd_cnt <= '0;
            end else if (state == BUSY && wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (fin_ack) begin
                last_owner <= owner;
            end
        end
    end

    // Downstream request port, latched at grant and held through BUSY.
    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            grant     <= 2'b00;
        end else if (start) begin
            mem_req   <= 1'b1;
            mem_addr  <= pick ? m1_addr : m0_addr;
            mem_wdata <= pick ? m1_wdata : m0_wdata;
            mem_we    <= pick ? m1_we : m0_we;
            grant     <= pick ? 2'b10 : 2'b01;
        end else if (fin_ack || fin_to) begin
            mem_req   <= 1'b0;
            grant     <= 2'b00;
        end
    end

    // Per-master completion: one-cycle done/err, rdata held until next one.
    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            m0_rdata <= '0;
            m0_done  <= 1'b0;
            m0_err   <= 1'b0;
            m1_rdata <= '0;
            m1_done  <= 1'b0;
            m1_err   <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m0_err  <= 1'b0;
            m1_done <= 1'b0;
            m1_err  <= 1'b0;
            if (fin_ack) begin
                if (owner) begin
                    m1_done  <= 1'b1;
                    m1_rdata <= mem_rdata;
                end else begin
                    m0_done  <= 1'b1;
                    m0_rdata <= mem_rdata;
                end
            end else if (fin_to) begin
                if (owner) begin
                    m1_done  <= 1'b1;
                    m1_err   <= 1'b1;
                    m1_rdata <= '0;
                end else begin
                    m0_done  <= 1'b1;
                    m0_err   <= 1'b1;
                    m0_rdata <= '0;
                end
            end
        end
    end

    // Saturating timeout counter.
    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            err_count <= 8'd0;
        end else if (fin_to && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter in front of the physical memory controller. Master 0 is the CPU data/instruction path; master 1 is a DMA-capable peripheral (sl811 buffer mover or VGA blitter).
- Serialises their single-word read/write requests onto one downstream memory request/acknowledge port.
- Selects round-robin or fixed CPU priority, and converts a hung memory access into an error completion via a watchdog timeout.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data word width.
- CPU_PRIORITY, 0, 1 = master 0 always wins ties; 0 = round-robin.
- TIMEOUT, 1023, cycles to wait for mem_ack before aborting; 0 disables the watchdog.

Ports:
- clk50M  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; level signal.
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_we  in  1  master 0 write enable (1 = write).
- m0_rdata  out  DATA_WIDTH  master 0 read data; valid while m0_done is high.
- m0_done  out  1  master 0 completion pulse; one cycle.
- m0_err  out  1  master 0 timeout flag; qualified by m0_done.
- m1_req, m1_addr, m1_wdata, m1_we, m1_rdata, m1_done, m1_err: same as master 0, for master 1.
- mem_req  out  1  downstream request; held until acknowledged.
- mem_addr  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  DATA_WIDTH  downstream write data.
- mem_we  out  1  downstream write enable.
- mem_rdata  in  DATA_WIDTH  downstream read data; valid with mem_ack.
- mem_ack  in  1  downstream completion; one-cycle pulse.
- grant  out  2  one-hot owner of the current transaction; 00 when idle.
- err_count  out  8  saturating count of timeouts.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - All outputs 0, including mem_req, grant, done, err, rdata and err_count.
  - last_owner=1, so master 0 wins the first tie.
- All outputs are registered. Masters hold req and operands stable until they see their done.
- IDLE:
  - At an edge with any req high, pick the winner.
  - Only one master requesting: that master wins.
  - Both requesting: with CPU_PRIORITY=1, m0 wins; with CPU_PRIORITY=0, the master that is not last_owner wins.
  - On winning: latch the winner's addr/wdata/we into mem_*, set mem_req=1, set grant, clear the watchdog counter, go to BUSY.
- BUSY:
  - mem_* are held constant. Requests from either master are ignored.
  - mem_ack high at an edge:
    - mem_req=0, grant=00.
    - Winner's rdata=mem_rdata; on writes, rdata is also loaded with mem_rdata and is don't-care.
    - Winner's done=1, err=0; last_owner=winner; go to DONE.
  - Watchdog (TIMEOUT≠0), counter reaches TIMEOUT with no ack:
    - mem_req=0, grant=00, winner's done=1, err=1, rdata=0.
    - err_count increments and saturates at 255; go to DONE.
  - mem_ack and the timeout on the same edge: the ack wins; no error.
- DONE (exactly one cycle):
  - done/err are high during this cycle and cleared at the next edge. rdata holds until the next completion for that master.
  - New requests are not sampled. This lets the finished master drop req or present new operands.
  - Next state is IDLE.
- Latency:
  - req sampled at edge E gives mem_req high after E.
  - mem_ack sampled at edge A gives done high for the cycle after A.
  - Back-to-back throughput per transaction is (memory latency + 3) cycles.
- mem_ack arriving in IDLE or DONE (a late ack after a timeout) is ignored and causes no done pulse.
- A master dropping req while BUSY does not abort the transaction; its done is still issued.
- Reset asserted mid-BUSY: mem_req drops immediately and no done is issued. The memory controller is reset by the same rst.
- The watchdog counter is ceil(log2(TIMEOUT+1)) bits and saturates. It counts only in BUSY.

Test Plan:
- Single read: m0_req=1, m0_addr=0x00000100, m0_we=0; memory acks 4 cycles after mem_req with 0xDEADBEEF -> mem_addr=0x100, mem_req high for exactly 5 cycles, m0_rdata=0xDEADBEEF with m0_done pulsing once, m0_err=0, grant=01 while busy.
- Round-robin contention (CPU_PRIORITY=0): m0 and m1 requesting continuously from reset, ack latency 2 -> grants alternate 01,10,01,10; each done fires once per grant; a transaction starts every 5 cycles.
- Fixed priority (CPU_PRIORITY=1): m0 requests continuously, m1 requests once -> m1 is never granted while m0_req is high; m1 is granted on the first IDLE in which m0_req is low.
- Timeout (TIMEOUT=8): m1 write to 0x00000200, mem_ack never asserted -> mem_req drops after 8 BUSY cycles; m1_done=1, m1_err=1, m1_rdata=0; err_count=1; an ack injected 3 cycles later causes no done.
- Simultaneous ack and timeout at count 8 -> normal completion, err=0, err_count unchanged.
- Reset mid-BUSY: assert rst low asynchronously between clock edges -> mem_req, grant and all done lines read 0 before the next edge; after release, m0 wins the first tie.
